// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - shared constants and types for the operand entry stage
package operand_entry_pkg;

    typedef enum logic {
        ST_EDIT_A = 1'b0,
        ST_EDIT_B = 1'b1
    } state_e;

    localparam int K_INC = 0;
    localparam int K_DEC = 1;
    localparam int K_SEL = 2;
    localparam int K_CLR = 3;

    localparam int unsigned DEF_TICK_DIV = 240000;

endpackage

// File: rtl/operand_entry_if.sv
// rtl/operand_entry_if.sv - key inputs and operand outputs of the operand entry stage
interface operand_entry_if;

    logic [3:0] key_n;
    logic [3:0] num1;
    logic [3:0] num2;
    logic       edit_sel;
    logic       upd;

    modport master (
        input  key_n,
        output num1,
        output num2,
        output edit_sel,
        output upd
    );

    modport slave (
        output key_n,
        input  num1,
        input  num2,
        input  edit_sel,
        input  upd
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronise, debounce and edge-detect one active-low key
module key_debounce #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   samp_q, samp_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], key_n};
        samp_d   = samp_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (tick) begin
            samp_d = sync_out;
            // Level accepted only after two consecutive ticks agree.
            if ((sync_out == samp_q) && (sync_out != stable_q)) begin
                stable_d = sync_out;
                press_d  = ~sync_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            samp_q   <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            samp_q   <= samp_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - debounced key entry of two 4-bit adder operands
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_entry_if.master        bus
);

    logic [23:0] cnt_q, cnt_d;
    logic        tick;
    logic [3:0]  press;

    assign tick = (cnt_q == 24'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? 24'd0 : cnt_q + 24'd1;
    end

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_key (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .key_n (bus.key_n[k]),
            .press (press[k])
        );
    end

    state_e     state_q, state_d;
    logic [3:0] num1_q, num1_d;
    logic [3:0] num2_q, num2_d;
    logic       upd_q, upd_d;

    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        upd_d   = 1'b0;
        if (press[K_CLR]) begin
            num1_d  = 4'd0;
            num2_d  = 4'd0;
            state_d = ST_EDIT_A;
            upd_d   = 1'b1;
        end else begin
            // inc and dec together cancel; arithmetic uses the pre-toggle selection.
            if (press[K_INC] ^ press[K_DEC]) begin
                if (state_q == ST_EDIT_A)
                    num1_d = press[K_INC] ? num1_q + 4'd1 : num1_q - 4'd1;
                else
                    num2_d = press[K_INC] ? num2_q + 4'd1 : num2_q - 4'd1;
                upd_d = 1'b1;
            end
            if (press[K_SEL])
                state_d = (state_q == ST_EDIT_A) ? ST_EDIT_B : ST_EDIT_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 24'd0;
            state_q <= ST_EDIT_A;
            num1_q  <= 4'd0;
            num2_q  <= 4'd0;
            upd_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.num1     = num1_q;
    assign bus.num2     = num2_q;
    assign bus.edit_sel = state_q;
    assign bus.upd      = upd_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - directed self-checking bench for operand_entry
module tb_operand_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   upd_cnt = 0;
    int   upd_mark = 0;

    operand_entry_if bus ();

    operand_entry #(
        .TICK_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.upd === 1'b1) upd_cnt = upd_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int n1, input int n2,
                             input int sel, input int upd_delta);
        chk({tag, ".num1"}, int'(bus.num1), n1);
        chk({tag, ".num2"}, int'(bus.num2), n2);
        chk({tag, ".edit_sel"}, int'(bus.edit_sel), sel);
        chk({tag, ".upd_cnt"}, upd_cnt - upd_mark, upd_delta);
        upd_mark = upd_cnt;
    endtask

    // mask bit set = key pressed; held 12 cycles, released 12 cycles
    task automatic press(input logic [3:0] mask);
        @(negedge clk);
        bus.key_n = ~mask;
        repeat (12) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        bus.key_n = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst.num1", int'(bus.num1), 0);
        chk("rst.num2", int'(bus.num2), 0);
        chk("rst.edit_sel", int'(bus.edit_sel), 0);
        chk("rst.upd", int'(bus.upd), 0);
        upd_mark = upd_cnt;

        rst = 1'b0;
        repeat (20) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (12) @(negedge clk);
        chk_state("held_thru_rst", 0, 0, 0, 1);

        press(4'b0001);
        chk_state("inc1", 1, 0, 0, 1);
        press(4'b0001);
        chk_state("inc2", 2, 0, 0, 1);
        press(4'b0001);
        chk_state("inc3", 3, 0, 0, 1);

        for (int i = 0; i < 10; i++) begin
            bus.key_n[0] = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        bus.key_n[0] = 1'b0;
        repeat (12) @(negedge clk);
        bus.key_n = 4'hF;
        repeat (12) @(negedge clk);
        chk_state("bounce", 4, 0, 0, 1);

        press(4'b0100);
        chk_state("sel_b", 4, 0, 1, 0);
        press(4'b0010);
        chk_state("dec_wrap", 4, 15, 1, 1);
        press(4'b0001);
        chk_state("inc_wrap", 4, 0, 1, 1);

        press(4'b0100);
        chk_state("sel_a", 4, 0, 0, 0);
        press(4'b0001);
        chk_state("inc_to5", 5, 0, 0, 1);
        press(4'b0011);
        chk_state("inc_dec", 5, 0, 0, 0);
        press(4'b0101);
        chk_state("sel_inc", 6, 0, 1, 1);

        press(4'b0100);
        for (int i = 0; i < 3; i++) press(4'b0001);
        press(4'b0100);
        for (int i = 0; i < 7; i++) press(4'b0001);
        chk_state("setup97", 9, 7, 1, 10);
        press(4'b1000);
        chk_state("clr", 0, 0, 0, 1);

        @(negedge clk);
        bus.key_n = 4'b1110;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_state("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        chk_state("held_after_rst", 1, 0, 0, 1);
        bus.key_n = 4'hF;
        repeat (12) @(negedge clk);
        chk_state("release", 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
